// File: rtl/timing_pkg.sv
// rtl/timing_pkg.sv - shared FSM type, default timing constants and helpers for timing_sync_rx
package timing_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEEK = 2'd1,
      ST_RUN  = 2'd2,
      ST_TAIL = 2'd3
   } state_e;

   // Defaults for a 120 MHz system clock: 370 us PRI, 513 PRIs per CPI
   localparam int unsigned PRI_EXP_DEF     = 44400;
   localparam int unsigned PRI_TOL_DEF     = 120;
   localparam int unsigned PRI_PER_CPI_DEF = 513;
   localparam int unsigned TIMEOUT_DEF     = 88800;

   // clk cycles per microsecond
   localparam int unsigned CLK_1US_CNT = 120;

   // Clamp a cycle count into a 16-bit field
   function automatic logic [15:0] sat16(input logic [31:0] v);
      return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
   endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchronizer with a registered one-cycle rise pulse
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic rise_q;

   // Resynchronize the pin, keep the previous level and register the rise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         meta_q <= pin_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/timing_sync_rx.sv
// rtl/timing_sync_rx.sv - PRI/CPI timing receiver: lock FSM, PRI indexing, period and sync measurement
module timing_sync_rx
   import timing_pkg::*;
#(
   parameter int unsigned PRI_EXP     = PRI_EXP_DEF,
   parameter int unsigned PRI_TOL     = PRI_TOL_DEF,
   parameter int unsigned PRI_PER_CPI = PRI_PER_CPI_DEF,
   parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        cpib_in,
   input  logic        cpie_in,
   input  logic        pri_in,
   input  logic        sync_in,
   input  logic        err_clr,
   output logic        locked,
   output logic        pri_stb,
   output logic [9:0]  pri_idx,
   output logic        cpi_stb,
   output logic [15:0] cpi_cnt,
   output logic [31:0] pri_period,
   output logic [15:0] sync_dly,
   output logic        meas_vld,
   output logic        period_err,
   output logic        count_err,
   output logic        seq_err,
   output logic        timeout_err
);

   localparam logic [31:0] PERIOD_LO = 32'(PRI_EXP - PRI_TOL);
   localparam logic [31:0] PERIOD_HI = 32'(PRI_EXP + PRI_TOL);
   localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
   localparam logic [9:0]  IDX_EXP   = 10'(PRI_PER_CPI);
   localparam logic [9:0]  IDX_MAX   = 10'd1023;

   logic cpib_r, cpie_r, pri_r, sync_r;

   edge_sync u_cpib (.clk(clk), .rst(rst), .pin_i(cpib_in), .rise_o(cpib_r));
   edge_sync u_cpie (.clk(clk), .rst(rst), .pin_i(cpie_in), .rise_o(cpie_r));
   edge_sync u_pri  (.clk(clk), .rst(rst), .pin_i(pri_in),  .rise_o(pri_r));
   edge_sync u_sync (.clk(clk), .rst(rst), .pin_i(sync_in), .rise_o(sync_r));

   state_e      state_q, state_d;
   logic [9:0]  pri_idx_q, pri_idx_d;
   logic [15:0] cpi_cnt_q, cpi_cnt_d;
   logic [31:0] per_cnt_q, per_cnt_d;
   logic [31:0] pri_period_q, pri_period_d;
   logic [15:0] sync_dly_q, sync_dly_d;
   logic        sync_arm_q, sync_arm_d;
   logic        pri_stb_q, pri_stb_d;
   logic        cpi_stb_q, cpi_stb_d;
   logic        meas_vld_q, meas_vld_d;
   logic        period_err_q, period_err_d;
   logic        count_err_q, count_err_d;
   logic        seq_err_q, seq_err_d;
   logic        timeout_err_q, timeout_err_d;

   logic        acc_cpib, acc_pri;
   logic        pe_set, ce_set, se_set, te_set;
   logic [9:0]  idx_base;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, event acceptance, counters and error flag updates
   always_comb begin
      state_d      = state_q;
      pri_idx_d    = pri_idx_q;
      cpi_cnt_d    = cpi_cnt_q;
      per_cnt_d    = per_cnt_q;
      pri_period_d = pri_period_q;
      sync_dly_d   = sync_dly_q;
      sync_arm_d   = sync_arm_q;
      pri_stb_d    = 1'b0;
      cpi_stb_d    = 1'b0;
      meas_vld_d   = 1'b0;
      acc_cpib     = 1'b0;
      acc_pri      = 1'b0;
      pe_set       = 1'b0;
      ce_set       = 1'b0;
      se_set       = 1'b0;
      te_set       = 1'b0;
      idx_base     = pri_idx_q;

      if (!enable) begin
         state_d      = ST_IDLE;
         pri_idx_d    = '0;
         cpi_cnt_d    = '0;
         per_cnt_d    = '0;
         pri_period_d = '0;
         sync_dly_d   = '0;
         sync_arm_d   = 1'b0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_SEEK;
      end else begin
         // cpib is handled before a coincident pri, so that pri lands in RUN
         acc_cpib = cpib_r;
         acc_pri  = pri_r & (acc_cpib | (state_q == ST_RUN));

         case (state_q)
            ST_SEEK: begin
               if (cpib_r) begin
                  state_d = ST_RUN;
               end else if (cpie_r) begin
                  se_set = 1'b1;
               end
            end
            ST_RUN: begin
               if (cpib_r) begin
                  se_set = 1'b1;
               end else if (cpie_r) begin
                  state_d = ST_TAIL;
                  ce_set  = (pri_idx_q != IDX_EXP);
               end else if (!acc_pri && (per_cnt_q >= TIMEOUT_C)) begin
                  state_d = ST_SEEK;
                  te_set  = 1'b1;
               end
            end
            ST_TAIL: begin
               if (cpib_r) begin
                  state_d = ST_RUN;
               end else if (cpie_r) begin
                  se_set = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (acc_cpib) begin
            cpi_cnt_d = cpi_cnt_q + 16'd1;
            cpi_stb_d = 1'b1;
            idx_base  = '0;
            pri_idx_d = '0;
         end

         if (acc_pri) begin
            pri_stb_d = 1'b1;
            pri_idx_d = (idx_base == IDX_MAX) ? IDX_MAX : idx_base + 10'd1;
            per_cnt_d = 32'd1;
            // The first PRI of a CPI has no valid predecessor to measure against
            if (!acc_cpib && (pri_idx_q != 10'd0)) begin
               pri_period_d = per_cnt_q;
               meas_vld_d   = 1'b1;
               pe_set       = (per_cnt_q < PERIOD_LO) || (per_cnt_q > PERIOD_HI);
            end
         end else if (per_cnt_q != 32'hFFFF_FFFF) begin
            per_cnt_d = per_cnt_q + 32'd1;
         end

         // The period counter doubles as the elapsed time since the last PRI
         if (acc_pri) begin
            if (sync_r) begin
               sync_dly_d = '0;
               sync_arm_d = 1'b0;
            end else begin
               sync_arm_d = 1'b1;
            end
         end else if (sync_arm_q && sync_r) begin
            sync_dly_d = sat16(per_cnt_q);
            sync_arm_d = 1'b0;
         end
      end

      // A set in the same cycle as a clear wins
      period_err_d  = pe_set | (period_err_q  & ~err_clr);
      count_err_d   = ce_set | (count_err_q   & ~err_clr);
      seq_err_d     = se_set | (seq_err_q     & ~err_clr);
      timeout_err_d = te_set | (timeout_err_q & ~err_clr);
   end

   // Datapath, strobe and sticky flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pri_idx_q     <= '0;
         cpi_cnt_q     <= '0;
         per_cnt_q     <= '0;
         pri_period_q  <= '0;
         sync_dly_q    <= '0;
         sync_arm_q    <= 1'b0;
         pri_stb_q     <= 1'b0;
         cpi_stb_q     <= 1'b0;
         meas_vld_q    <= 1'b0;
         period_err_q  <= 1'b0;
         count_err_q   <= 1'b0;
         seq_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         pri_idx_q     <= pri_idx_d;
         cpi_cnt_q     <= cpi_cnt_d;
         per_cnt_q     <= per_cnt_d;
         pri_period_q  <= pri_period_d;
         sync_dly_q    <= sync_dly_d;
         sync_arm_q    <= sync_arm_d;
         pri_stb_q     <= pri_stb_d;
         cpi_stb_q     <= cpi_stb_d;
         meas_vld_q    <= meas_vld_d;
         period_err_q  <= period_err_d;
         count_err_q   <= count_err_d;
         seq_err_q     <= seq_err_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign locked      = (state_q == ST_RUN) || (state_q == ST_TAIL);
   assign pri_stb     = pri_stb_q;
   assign pri_idx     = pri_idx_q;
   assign cpi_stb     = cpi_stb_q;
   assign cpi_cnt     = cpi_cnt_q;
   assign pri_period  = pri_period_q;
   assign sync_dly    = sync_dly_q;
   assign meas_vld    = meas_vld_q;
   assign period_err  = period_err_q;
   assign count_err   = count_err_q;
   assign seq_err     = seq_err_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_timing_sync_rx.sv
// tb/tb_timing_sync_rx.sv - scoreboard bench for timing_sync_rx with scaled-down timing parameters
module tb_timing_sync_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        cpib_in = 1'b0;
   logic        cpie_in = 1'b0;
   logic        pri_in = 1'b0;
   logic        sync_in = 1'b0;
   logic        err_clr = 1'b0;
   logic        locked, pri_stb, cpi_stb, meas_vld;
   logic [9:0]  pri_idx;
   logic [15:0] cpi_cnt, sync_dly;
   logic [31:0] pri_period;
   logic        period_err, count_err, seq_err, timeout_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_pri_cyc = 0;

   typedef struct {
      int idx;
      int cpi;
   } pri_exp_t;

   pri_exp_t pri_q[$];
   int       cpi_q[$];
   int       meas_q[$];

   timing_sync_rx #(
      .PRI_EXP(40), .PRI_TOL(3), .PRI_PER_CPI(5), .TIMEOUT(100)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .cpib_in(cpib_in), .cpie_in(cpie_in), .pri_in(pri_in), .sync_in(sync_in),
      .err_clr(err_clr), .locked(locked), .pri_stb(pri_stb), .pri_idx(pri_idx),
      .cpi_stb(cpi_stb), .cpi_cnt(cpi_cnt), .pri_period(pri_period), .sync_dly(sync_dly),
      .meas_vld(meas_vld), .period_err(period_err), .count_err(count_err),
      .seq_err(seq_err), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pop expected responses whenever the DUT strobes
   always @(negedge clk) begin
      if (pri_stb) begin
         pri_exp_t e;
         last_pri_cyc = cyc;
         if (pri_q.size() == 0) begin
            chk("pri_stb_unexpected", 1, 0);
         end else begin
            e = pri_q.pop_front();
            chk("pri_idx", pri_idx, e.idx);
            chk("pri_cpi_cnt", cpi_cnt, e.cpi);
         end
      end
      if (cpi_stb) begin
         if (cpi_q.size() == 0) chk("cpi_stb_unexpected", 1, 0);
         else chk("cpi_cnt", cpi_cnt, cpi_q.pop_front());
      end
      if (meas_vld) begin
         if (meas_q.size() == 0) chk("meas_vld_unexpected", 1, 0);
         else chk("pri_period", pri_period, meas_q.pop_front());
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raise the chosen pins for one cycle, then idle so the next fire is gap cycles later
   task automatic fire(input logic b, input logic p, input logic e, input logic s, input int gap);
      cpib_in = b;
      pri_in  = p;
      cpie_in = e;
      sync_in = s;
      step(1);
      cpib_in = 1'b0;
      pri_in  = 1'b0;
      cpie_in = 1'b0;
      sync_in = 1'b0;
      step(gap - 1);
   endtask

   task automatic exp_pri(input int idx, input int cpi);
      pri_exp_t e;
      e.idx = idx;
      e.cpi = cpi;
      pri_q.push_back(e);
   endtask

   // One CPI: cpib with PRI 1, n PRIs separated by the given gaps, cpie 20 cycles after the last PRI
   task automatic run_cpi(input int cpi, input int n, input int g1, input int g2, input int g3, input int g4);
      int g[4];
      g = '{g1, g2, g3, g4};
      cpi_q.push_back(cpi);
      for (int i = 1; i <= n; i++) begin
         int gap;
         gap = (i < n) ? g[i-1] : 20;
         exp_pri(i, cpi);
         if (i > 1) meas_q.push_back(g[i-2]);
         fire((i == 1), 1'b1, 1'b0, 1'b0, gap);
      end
      fire(1'b0, 1'b0, 1'b1, 1'b0, 10);
   endtask

   initial begin
      int waited;

      // Reset state
      step(3);
      chk("rst_locked", locked, 0);
      chk("rst_pri_stb", pri_stb, 0);
      chk("rst_cpi_stb", cpi_stb, 0);
      chk("rst_meas_vld", meas_vld, 0);
      chk("rst_pri_idx", pri_idx, 0);
      chk("rst_cpi_cnt", cpi_cnt, 0);
      chk("rst_pri_period", pri_period, 0);
      chk("rst_sync_dly", sync_dly, 0);
      chk("rst_flags", {period_err, count_err, seq_err, timeout_err}, 0);
      rst = 1'b0;
      enable = 1'b1;
      step(3);
      chk("seek_locked", locked, 0);

      // Nominal CPI
      run_cpi(1, 5, 40, 40, 40, 40);
      chk("nom_locked_tail", locked, 1);
      chk("nom_pri_idx", pri_idx, 5);
      chk("nom_pri_period", pri_period, 40);
      chk("nom_flags", {period_err, count_err, seq_err, timeout_err}, 0);

      // Periods on both inclusive tolerance bounds
      run_cpi(2, 5, 40, 43, 37, 40);
      chk("bound_period_err", period_err, 0);
      chk("bound_count_err", count_err, 0);
      chk("bound_seq_err", seq_err, 0);

      // One period just outside tolerance
      run_cpi(3, 5, 40, 44, 40, 40);
      chk("drift_period_err", period_err, 1);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      chk("drift_period_err_clr", period_err, 0);

      // Short CPI
      run_cpi(4, 4, 40, 40, 40, 0);
      chk("short_count_err", count_err, 1);
      chk("short_pri_idx", pri_idx, 4);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      chk("short_count_err_clr", count_err, 0);

      // Sync delay, coincident sync, then cpib in RUN without cpie
      cpi_q.push_back(5);
      exp_pri(1, 5);
      fire(1'b1, 1'b1, 1'b0, 1'b0, 18);
      fire(1'b0, 1'b0, 1'b0, 1'b1, 10);
      chk("sync_dly_18", sync_dly, 18);
      step(12);
      exp_pri(2, 5);
      meas_q.push_back(40);
      fire(1'b0, 1'b1, 1'b0, 1'b1, 10);
      chk("sync_dly_same", sync_dly, 0);
      step(30);
      cpi_q.push_back(6);
      exp_pri(1, 6);
      fire(1'b1, 1'b1, 1'b0, 1'b0, 10);
      chk("seq_err_set", seq_err, 1);
      chk("seq_pri_idx", pri_idx, 1);
      chk("seq_locked", locked, 1);

      // Stall: no further PRIs
      waited = 0;
      while (!timeout_err && waited < 300) begin
         step(1);
         waited++;
      end
      chk("timeout_err_set", timeout_err, 1);
      chk("timeout_delay", cyc - last_pri_cyc, 100);
      chk("timeout_locked", locked, 0);

      // Enable low for one cycle: counters cleared, flags kept
      enable = 1'b0;
      step(1);
      chk("en_locked", locked, 0);
      chk("en_pri_idx", pri_idx, 0);
      chk("en_cpi_cnt", cpi_cnt, 0);
      chk("en_pri_period", pri_period, 0);
      chk("en_sync_dly", sync_dly, 0);
      chk("en_flags_kept", {period_err, count_err, seq_err, timeout_err}, 4'b0011);
      enable = 1'b1;
      step(3);

      // Reset mid-CPI with a PRI rise still in the synchronizer
      cpi_q.push_back(1);
      exp_pri(1, 1);
      fire(1'b1, 1'b1, 1'b0, 1'b0, 40);
      chk("pre_rst_locked", locked, 1);
      pri_in = 1'b1;
      step(1);
      pri_in = 1'b0;
      step(1);
      rst = 1'b1;
      #1;
      chk("mid_rst_locked", locked, 0);
      chk("mid_rst_pri_idx", pri_idx, 0);
      chk("mid_rst_cpi_cnt", cpi_cnt, 0);
      chk("mid_rst_flags", {period_err, count_err, seq_err, timeout_err}, 0);
      step(3);
      rst = 1'b0;
      step(10);
      chk("post_rst_locked", locked, 0);
      fire(1'b0, 1'b1, 1'b0, 1'b0, 10);
      chk("seek_pri_ignored", pri_idx, 0);
      cpi_q.push_back(1);
      exp_pri(1, 1);
      fire(1'b1, 1'b1, 1'b0, 1'b0, 10);
      chk("relock_locked", locked, 1);
      chk("relock_pri_idx", pri_idx, 1);

      step(5);
      chk("pri_q_left", pri_q.size(), 0);
      chk("cpi_q_left", cpi_q.size(), 0);
      chk("meas_q_left", meas_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
